// File: rtl/dmg_timer.sv
// dmg_timer: DMG DIV/TIMA/TMA/TAC timer with falling-edge tick detection and overflow/reload sequencing.
module dmg_timer (
  input  logic       clk,
  input  logic       areset,
  input  logic       sel,
  input  logic [1:0] adr,
  input  logic [7:0] din,
  input  logic       wr,
  output logic [7:0] dout,
  output logic       irq_timer
);
  typedef enum logic [1:0] {IDLE, OVF, RELOAD} st_t;
  st_t st_q, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0] tima_q, tima_d, tma_q, tma_d, inc;
  logic [2:0] tac_q, tac_d;
  logic [1:0] ph_q, ph_d;
  logic tap, tap_q, tick, irq_q, irq_d, carry;
  logic we_div, we_tima, we_tma, we_tac;
  assign we_div  = sel & wr & (adr == 2'd0);
  assign we_tima = sel & wr & (adr == 2'd1);
  assign we_tma  = sel & wr & (adr == 2'd2);
  assign we_tac  = sel & wr & (adr == 2'd3);
  assign tap = tac_q[2] & (tac_q[1:0] == 2'd0 ? cnt_q[9] :
                           tac_q[1:0] == 2'd1 ? cnt_q[3] :
                           tac_q[1:0] == 2'd2 ? cnt_q[5] : cnt_q[7]);
  assign tick = tap_q & ~tap;
  assign {carry, inc} = {1'b0, tima_q} + 9'd1;
  assign cnt_d = we_div ? 16'd0 : cnt_q + 16'd1;
  assign tma_d = we_tma ? din : tma_q;
  assign tac_d = we_tac ? din[2:0] : tac_q;
  assign dout = !sel ? 8'hFF :
                adr == 2'd0 ? cnt_q[15:8] :
                adr == 2'd1 ? tima_q :
                adr == 2'd2 ? tma_q : {5'b11111, tac_q};
  assign irq_timer = irq_q;
  always_comb begin
    st_d = st_q;
    ph_d = ph_q + 2'd1;
    tima_d = tima_q;
    irq_d = 1'b0;
    case (st_q)
      IDLE: begin
        if (we_tima) tima_d = din;
        else if (tick) begin
          tima_d = inc;
          if (carry) begin
            st_d = OVF;
            ph_d = 2'd0;
          end
        end
      end
      OVF: begin
        if (we_tima) begin
          tima_d = din;
          st_d = IDLE;
        end else if (ph_q == 2'd3) begin
          // a TMA write on the reload edge is already visible to the reload
          tima_d = tma_d;
          irq_d = 1'b1;
          st_d = RELOAD;
          ph_d = 2'd0;
        end else if (tick) tima_d = inc;
      end
      RELOAD: begin
        if (we_tma) tima_d = din;
        if (ph_q == 2'd3) begin
          st_d = IDLE;
          if (tick && !we_tma) begin
            tima_d = inc;
            if (carry) begin
              st_d = OVF;
              ph_d = 2'd0;
            end
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cnt_q <= 16'd0;
      tima_q <= 8'd0;
      tma_q <= 8'd0;
      tac_q <= 3'd0;
      tap_q <= 1'b0;
      st_q <= IDLE;
      ph_q <= 2'd0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tima_q <= tima_d;
      tma_q <= tma_d;
      tac_q <= tac_d;
      tap_q <= tap;
      st_q <= st_d;
      ph_q <= ph_d;
      irq_q <= irq_d;
    end
  end
endmodule
